// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: ALU control codes, request
// opcodes, the ALU drive bundle and the opcode-to-ALU mapping.
package alu_sequencer_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SR  = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  localparam logic [3:0] OP_ADC = 4'h0;
  localparam logic [3:0] OP_SBC = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ORA = 4'h3;
  localparam logic [3:0] OP_EOR = 4'h4;
  localparam logic [3:0] OP_ASL = 4'h5;
  localparam logic [3:0] OP_LSR = 4'h6;
  localparam logic [3:0] OP_ROL = 4'h7;
  localparam logic [3:0] OP_ROR = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_ADW = 4'hC;

  typedef struct packed {
    logic [2:0] ctrl;
    logic [7:0] ai;
    logic [7:0] bi;
    logic       ci;
  } alu_drive_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_ADW;
  endfunction

  // Ops whose carry comes from the ALU; all others pass p_c through.
  function automatic logic writes_carry(input logic [3:0] op);
    return (op == OP_ADC) || (op == OP_SBC) || (op == OP_CMP) || (op == OP_ASL) ||
           (op == OP_LSR) || (op == OP_ROL) || (op == OP_ROR) || (op == OP_ADW);
  endfunction

  // Ops whose overflow comes from the ALU; all others pass p_v through.
  function automatic logic writes_overflow(input logic [3:0] op);
    return (op == OP_ADC) || (op == OP_SBC) || (op == OP_ADW);
  endfunction

  // Low-byte ALU drive for each opcode. ADW's low byte is a plain ADC.
  function automatic alu_drive_t map_op(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic c);
    alu_drive_t d;
    d = '{ctrl: ALU_ADD, ai: a, bi: b, ci: 1'b0};
    case (op)
      OP_ADC, OP_ADW: d.ci = c;
      OP_SBC: begin d.bi = ~b; d.ci = c; end
      OP_AND: d.ctrl = ALU_AND;
      OP_ORA: d.ctrl = ALU_OR;
      OP_EOR: d.ctrl = ALU_XOR;
      OP_ASL: d.bi = a;
      OP_ROL: begin d.bi = a; d.ci = c; end
      OP_LSR: begin d.ctrl = ALU_SR; d.bi = 8'h00; end
      OP_ROR: begin d.ctrl = ALU_SR; d.bi = 8'h00; d.ci = c; end
      OP_INC: begin d.bi = 8'h00; d.ci = 1'b1; end
      OP_DEC: d.bi = 8'hFF;
      OP_CMP: begin d.bi = ~b; d.ci = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bus between the instruction decoder (master) and the
// ALU sequencer (slave).
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        p_c;
  logic        p_v;
  logic        rsp_valid;
  logic [15:0] rsp_y;
  logic        rsp_n;
  logic        rsp_v;
  logic        rsp_z;
  logic        rsp_c;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, p_c, p_v,
    input  req_ready, rsp_valid, rsp_y, rsp_n, rsp_v, rsp_z, rsp_c, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, p_c, p_v,
    output req_ready, rsp_valid, rsp_y, rsp_n, rsp_v, rsp_z, rsp_c, rsp_err
  );
endinterface

// File: rtl/alu.sv
// Combinational 6502-style ALU primitives: ADD, shift-right, AND, OR, XOR.
module alu
  import alu_sequencer_pkg::*;
(
  input  logic [2:0] control,
  input  logic [7:0] ai,
  input  logic [7:0] bi,
  input  logic       carry_in,
  output logic [7:0] y,
  output logic       carry_out,
  output logic       overflow
);

  logic [8:0] sum;
  assign sum = {1'b0, ai} + {1'b0, bi} + {8'h00, carry_in};

  // Select the primitive; the adder result is the default.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    y         = sum[7:0];
    carry_out = sum[8];
    overflow  = (ai[7] == bi[7]) && (sum[7] != ai[7]);
    case (control)
      ALU_SR:  begin y = {carry_in, ai[7:1]}; carry_out = ai[0]; overflow = 1'b0; end
      ALU_AND: begin y = ai & bi; carry_out = 1'b0; overflow = 1'b0; end
      ALU_OR:  begin y = ai | bi; carry_out = 1'b0; overflow = 1'b0; end
      ALU_XOR: begin y = ai ^ bi; carry_out = 1'b0; overflow = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequential front end to the 6502 ALU: accepts one request at a time,
// drives the ALU from registers, and returns a result with N/V/Z/C flags.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  alu_sequencer_if.slave   bus,
  output logic [2:0]       alu_control,
  output logic [7:0]       alu_AI,
  output logic [7:0]       alu_BI,
  output logic             alu_carry_in,
  input  logic [7:0]       alu_Y,
  input  logic             alu_carry_out,
  input  logic             alu_overflow
);

  typedef enum logic [1:0] {IDLE, EXEC, EXEC_HI, DONE} state_e;

  state_e      state;
  logic [3:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        pc_q;
  logic        pv_q;
  logic [7:0]  lo_q;
  alu_drive_t  drv;

  // ALU drive for the request currently on the bus.
  always_comb drv = map_op(bus.req_op, bus.req_a[7:0], bus.req_b[7:0], bus.p_c);

  // Sequencer FSM with registered ALU drive and response outputs.
  // Illegal ops occupy the EXEC slot without touching the ALU so that every
  // non-ADW response appears with the same latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      pc_q          <= 1'b0;
      pv_q          <= 1'b0;
      lo_q          <= '0;
      alu_control   <= ALU_ADD;
      alu_AI        <= '0;
      alu_BI        <= '0;
      alu_carry_in  <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_y     <= '0;
      bus.rsp_n     <= 1'b0;
      bus.rsp_v     <= 1'b0;
      bus.rsp_z     <= 1'b0;
      bus.rsp_c     <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q          <= bus.req_op;
            a_q           <= bus.req_a;
            b_q           <= bus.req_b;
            pc_q          <= bus.p_c;
            pv_q          <= bus.p_v;
            bus.req_ready <= 1'b0;
            bus.rsp_err   <= 1'b0;
            if (is_legal(bus.req_op)) begin
              alu_control  <= drv.ctrl;
              alu_AI       <= drv.ai;
              alu_BI       <= drv.bi;
              alu_carry_in <= drv.ci;
            end
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!is_legal(op_q)) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_y     <= '0;
            bus.rsp_n     <= 1'b0;
            bus.rsp_v     <= pv_q;
            bus.rsp_z     <= 1'b0;
            bus.rsp_c     <= pc_q;
            bus.rsp_err   <= 1'b1;
            state         <= DONE;
          end else if (op_q == OP_ADW) begin
            lo_q         <= alu_Y;
            alu_control  <= ALU_ADD;
            alu_AI       <= a_q[15:8];
            alu_BI       <= b_q[15:8];
            alu_carry_in <= alu_carry_out;
            state        <= EXEC_HI;
          end else begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_y     <= {8'h00, (op_q == OP_CMP) ? a_q[7:0] : alu_Y};
            bus.rsp_n     <= alu_Y[7];
            bus.rsp_z     <= (alu_Y == 8'h00);
            bus.rsp_c     <= writes_carry(op_q) ? alu_carry_out : pc_q;
            bus.rsp_v     <= writes_overflow(op_q) ? alu_overflow : pv_q;
            state         <= DONE;
          end
        end
        EXEC_HI: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_y     <= {alu_Y, lo_q};
          bus.rsp_n     <= alu_Y[7];
          bus.rsp_z     <= (alu_Y == 8'h00) && (lo_q == 8'h00);
          bus.rsp_c     <= alu_carry_out;
          bus.rsp_v     <= alu_overflow;
          state         <= DONE;
        end
        DONE: begin
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer + alu with a scoreboard of expected
// responses built from a behavioural 6502 model at each accept.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] alu_control;
  logic [7:0] alu_AI, alu_BI, alu_Y;
  logic       alu_carry_in, alu_carry_out, alu_overflow;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .alu_control   (alu_control),
    .alu_AI        (alu_AI),
    .alu_BI        (alu_BI),
    .alu_carry_in  (alu_carry_in),
    .alu_Y         (alu_Y),
    .alu_carry_out (alu_carry_out),
    .alu_overflow  (alu_overflow)
  );

  alu u_alu (
    .control   (alu_control),
    .ai        (alu_AI),
    .bi        (alu_BI),
    .carry_in  (alu_carry_in),
    .y         (alu_Y),
    .carry_out (alu_carry_out),
    .overflow  (alu_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] y;
    logic        n, v, z, c, err;
    int          lat;   // edges from the accept edge to the edge raising rsp_valid
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          accepts = 0;
  logic [15:0] last_y = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference 6502 behaviour, written independently of the ALU mapping.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic pc, input logic pv);
    exp_t e;
    logic [7:0]  a8, b8, r;
    logic [8:0]  s;
    logic [16:0] w;
    a8 = a[7:0]; b8 = b[7:0]; r = '0; s = '0; w = '0;
    e.y = '0; e.n = 1'b0; e.v = pv; e.z = 1'b0; e.c = pc; e.err = 1'b0; e.lat = 1; e.acc = 0;
    case (op)
      4'h0: begin
        s = {1'b0, a8} + {1'b0, b8} + {8'h00, pc}; r = s[7:0]; e.c = s[8];
        e.v = (a8[7] == b8[7]) && (r[7] != a8[7]);
      end
      4'h1: begin
        s = {1'b0, a8} + {1'b0, ~b8} + {8'h00, pc}; r = s[7:0]; e.c = s[8];
        e.v = (a8[7] != b8[7]) && (r[7] != a8[7]);
      end
      4'h2: r = a8 & b8;
      4'h3: r = a8 | b8;
      4'h4: r = a8 ^ b8;
      4'h5: begin r = {a8[6:0], 1'b0}; e.c = a8[7]; end
      4'h6: begin r = {1'b0, a8[7:1]}; e.c = a8[0]; end
      4'h7: begin r = {a8[6:0], pc};   e.c = a8[7]; end
      4'h8: begin r = {pc, a8[7:1]};   e.c = a8[0]; end
      4'h9: r = a8 + 8'd1;
      4'hA: r = a8 - 8'd1;
      4'hB: begin
        s = {1'b0, a8} + {1'b0, ~b8} + 9'd1;
        e.y = {8'h00, a8}; e.n = s[7]; e.z = (s[7:0] == 8'h00); e.c = s[8];
        return e;
      end
      4'hC: begin
        w = {1'b0, a} + {1'b0, b} + {16'h0000, pc};
        e.y = w[15:0]; e.c = w[16]; e.n = w[15]; e.z = (w[15:0] == 16'h0000);
        e.v = (a[15] == b[15]) && (w[15] != a[15]); e.lat = 2;
        return e;
      end
      default: begin
        e.err = 1'b1;
        return e;
      end
    endcase
    e.y = {8'h00, r}; e.n = r[7]; e.z = (r == 8'h00);
    return e;
  endfunction

  // Cycle counter and scoreboard push on every accepted request.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (!rst && bus.req_valid && bus.req_ready) begin
      accepts = accepts + 1;
      e = model(bus.req_op, bus.req_a, bus.req_b, bus.p_c, bus.p_v);
      e.acc = cyc;
      sb.push_back(e);
    end
  end

  // Response monitor: pop and compare on each rsp_valid.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_y",   {16'h0, bus.rsp_y}, {16'h0, e.y});
        check("rsp_nvzc", {28'h0, bus.rsp_n, bus.rsp_v, bus.rsp_z, bus.rsp_c},
                          {28'h0, e.n, e.v, e.z, e.c});
        check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
        check("latency", cyc - e.acc, e.lat);
        last_y = e.y;
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, {31'h0, bus.req_ready}, 32'd1);
    check({tag, "_valid"}, {31'h0, bus.rsp_valid}, 32'd0);
    check({tag, "_y"}, {16'h0, bus.rsp_y}, 32'd0);
    check({tag, "_flags"}, {27'h0, bus.rsp_n, bus.rsp_v, bus.rsp_z, bus.rsp_c, bus.rsp_err}, 32'd0);
    check({tag, "_alu"}, {13'h0, alu_control, alu_AI, alu_BI, alu_carry_in}, 32'd0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic pc, input logic pv);
    @(negedge clk);
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.p_c = pc; bus.p_v = pv;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic pc, input logic pv);
    issue(op, a, b, pc, pv);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    logic [3:0] op;
    logic       pc;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.p_c = 1'b0; bus.p_v = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("init");
    rst = 1'b0;

    // Directed cases.
    send(4'h0, 16'h0050, 16'h0050, 1'b0, 1'b0);   // ADC overflow
    send(4'h1, 16'h0050, 16'h00F0, 1'b1, 1'b0);   // SBC borrow
    send(4'hB, 16'h0040, 16'h0040, 1'b0, 1'b1);   // CMP equal, V passes through
    send(4'h8, 16'h0001, 16'h0000, 1'b1, 1'b0);   // ROR carry in/out
    send(4'h6, 16'h0001, 16'h0000, 1'b0, 1'b0);   // LSR to zero
    send(4'h9, 16'h00FF, 16'h0000, 1'b0, 1'b0);   // INC wrap, C unchanged
    send(4'hA, 16'h0000, 16'h0000, 1'b1, 1'b1);   // DEC wrap
    send(4'h5, 16'h0081, 16'h0000, 1'b0, 1'b0);   // ASL
    send(4'h7, 16'h0040, 16'h0000, 1'b1, 1'b0);   // ROL
    send(4'h2, 16'h00F0, 16'h003C, 1'b1, 1'b1);   // AND
    send(4'h3, 16'h0080, 16'h0001, 1'b0, 1'b1);   // ORA
    send(4'h4, 16'h00AA, 16'h00AA, 1'b1, 1'b0);   // EOR to zero
    send(4'hC, 16'h12FF, 16'h0001, 1'b0, 1'b0);   // ADW carry across bytes
    send(4'hC, 16'hFFFF, 16'h0001, 1'b0, 1'b0);   // ADW wrap to zero
    send(4'hE, 16'h1234, 16'h5678, 1'b1, 1'b1);   // illegal
    send(4'h0, 16'h0001, 16'h0001, 1'b0, 1'b0);   // rsp_err clears

    repeat (3) @(negedge clk);
    check("rsp_y_hold", {16'h0, bus.rsp_y}, {16'h0, last_y});

    // req_valid held through the busy period: exactly one accept.
    acc0 = accepts;
    @(negedge clk);
    bus.req_op = 4'h0; bus.req_a = 16'h0011; bus.req_b = 16'h0022;
    bus.p_c = 1'b0; bus.p_v = 1'b0; bus.req_valid = 1'b1;
    @(negedge clk);
    check("busy_ready", {31'h0, bus.req_ready}, 32'd0);
    bus.req_op = 4'h4; bus.req_a = 16'h00FF;
    repeat (2) @(negedge clk);
    bus.req_valid = 1'b0;
    drain();
    check("busy_accepts", accepts - acc0, 32'd1);

    // Reset in EXEC_HI of an ADW aborts it.
    issue(4'hC, 16'h7F80, 16'h0180, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_ready", {31'h0, bus.req_ready}, 32'd1);
    send(4'h0, 16'h0033, 16'h0044, 1'b1, 1'b0);

    // Random mix, legal and illegal.
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      pc = (op == 4'hC) ? 1'b0 : 1'($urandom_range(0, 1));
      send(op, 16'($urandom), 16'($urandom), pc, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
